// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the data-RAM arbiter:
//   - arb_state_t : arbiter FSM state encoding
//   - REQ_CPU / REQ_IO : requester ids (control unit = 0, I/O-DMA = 1)
//   - LAT_CNT_W : width of the RAM read-latency down-counter
//   - lat_reload() : counter load value for a given RAM read latency
// ---------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_IO  = 1'b1;

    localparam int LAT_CNT_W = 4;

    // The WAIT state counts down to zero and samples on the zero cycle, so
    // the counter is loaded with one less than the latency.
    function automatic logic [LAT_CNT_W-1:0] lat_reload(input int lat);
        return LAT_CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker.
//   i_valid0, i_valid1 : pending requests
//   i_last_grant       : id of the most recently accepted requester
//   o_grant_vec[1:0]   : one-hot grant (all zero when nothing is pending)
//   o_grant_id         : id of the granted requester (REQ_CPU when idle)
// On a tie the requester that did not win last time is chosen.
// ---------------------------------------------------------------------------
module rr_pick2
    import arb_pkg::*;
(
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_last_grant,
    output logic [1:0] o_grant_vec,
    output logic       o_grant_id
);

    always_comb begin
        o_grant_vec = 2'b00;
        o_grant_id  = REQ_CPU;
        if (i_valid0 && i_valid1) begin
            if (i_last_grant == REQ_IO) begin
                o_grant_vec = 2'b01;
                o_grant_id  = REQ_CPU;
            end else begin
                o_grant_vec = 2'b10;
                o_grant_id  = REQ_IO;
            end
        end else if (i_valid0) begin
            o_grant_vec = 2'b01;
            o_grant_id  = REQ_CPU;
        end else if (i_valid1) begin
            o_grant_vec = 2'b10;
            o_grant_id  = REQ_IO;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Shares the single data-RAM port between the CPU control unit (req0) and
// the I/O / DMA engine (req1). One transaction is in flight at a time; a
// write takes IDLE+ISSUE, a read takes IDLE+ISSUE+RAM_LAT WAIT cycles and
// returns its data as a one-cycle rvalid pulse on the winning port.
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   i_reqN_valid/we/addr/wdata : requester N transaction (held until ready)
//   o_reqN_ready               : combinational accept, IDLE only
//   o_reqN_rvalid/rdata        : read return pulse / data held until the
//                                next read return to the same port
//   o_ram_rd/wr/addr/wdata     : RAM strobes, address and write data
//   i_ram_rdata                : RAM read data
//   o_busy                     : transaction in ISSUE or WAIT
//   o_last_grant               : id of the most recently accepted requester
//
// FSM states:
//   state    | meaning
//   ST_IDLE  | open for a new request; read data pulse shows here
//   ST_ISSUE | one cycle driving RAM strobe, address and write data
//   ST_WAIT  | waiting out the RAM read latency, address held
// ---------------------------------------------------------------------------
module ram_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_W  = 14,
    parameter int ADDR_W  = 12,
    parameter int RAM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req0_valid,
    input  logic              i_req0_we,
    input  logic [ADDR_W-1:0] i_req0_addr,
    input  logic [DATA_W-1:0] i_req0_wdata,
    output logic              o_req0_ready,
    output logic              o_req0_rvalid,
    output logic [DATA_W-1:0] o_req0_rdata,

    input  logic              i_req1_valid,
    input  logic              i_req1_we,
    input  logic [ADDR_W-1:0] i_req1_addr,
    input  logic [DATA_W-1:0] i_req1_wdata,
    output logic              o_req1_ready,
    output logic              o_req1_rvalid,
    output logic [DATA_W-1:0] o_req1_rdata,

    output logic              o_ram_rd,
    output logic              o_ram_wr,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,

    output logic              o_busy,
    output logic              o_last_grant
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = lat_reload(RAM_LAT);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;

    logic                  r_we;
    logic                  r_id;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_last_grant;
    logic [LAT_CNT_W-1:0]  r_lat_cnt;

    logic                  r_rvalid0;
    logic                  r_rvalid1;
    logic [DATA_W-1:0]     r_rdata0;
    logic [DATA_W-1:0]     r_rdata1;

    logic [1:0]            w_grant_vec;
    logic                  w_grant_id;
    logic                  w_idle_open;
    logic                  w_accept;
    logic                  w_rd_done;

    rr_pick2 u_pick (
        .i_valid0     (i_req0_valid),
        .i_valid1     (i_req1_valid),
        .i_last_grant (r_last_grant),
        .o_grant_vec  (w_grant_vec),
        .o_grant_id   (w_grant_id)
    );

    // ready is gated by reset so nothing is accepted in a reset cycle.
    assign w_idle_open  = (r_state == ST_IDLE) && !reset;
    assign o_req0_ready = w_idle_open && w_grant_vec[0];
    assign o_req1_ready = w_idle_open && w_grant_vec[1];

    // The picker only grants a valid requester, so any ready is an accept.
    assign w_accept     = o_req0_ready || o_req1_ready;

    assign w_rd_done    = (r_state == ST_WAIT) && (r_lat_cnt == '0);

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_ram_rd    = 1'b0;
        o_ram_wr    = 1'b0;
        o_busy      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_busy   = 1'b1;
                o_ram_rd = !r_we;
                o_ram_wr = r_we;
                w_state_nxt = r_we ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                o_busy = 1'b1;
                if (r_lat_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Transaction capture at accept
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we         <= 1'b0;
            r_id         <= REQ_CPU;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_last_grant <= REQ_IO;
        end else if (w_accept) begin
            r_id         <= w_grant_id;
            r_last_grant <= w_grant_id;
            if (w_grant_id == REQ_IO) begin
                r_we    <= i_req1_we;
                r_addr  <= i_req1_addr;
                r_wdata <= i_req1_wdata;
            end else begin
                r_we    <= i_req0_we;
                r_addr  <= i_req0_addr;
                r_wdata <= i_req0_wdata;
            end
        end
    end

    // The latched address/data stay on the RAM bus through ISSUE and WAIT.
    assign o_ram_addr   = r_addr;
    assign o_ram_wdata  = r_wdata;
    assign o_last_grant = r_last_grant;

    // -----------------------------------------------------------------------
    // Read-latency down-counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lat_cnt <= '0;
        end else if ((r_state == ST_ISSUE) && !r_we) begin
            r_lat_cnt <= LAT_LOAD;
        end else if ((r_state == ST_WAIT) && (r_lat_cnt != '0)) begin
            r_lat_cnt <= r_lat_cnt - LAT_CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Read return: data sampled on the terminal WAIT cycle, pulse follows
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= w_rd_done && (r_id == REQ_CPU);
            r_rvalid1 <= w_rd_done && (r_id == REQ_IO);
            if (w_rd_done && (r_id == REQ_CPU)) begin
                r_rdata0 <= i_ram_rdata;
            end
            if (w_rd_done && (r_id == REQ_IO)) begin
                r_rdata1 <= i_ram_rdata;
            end
        end
    end

    assign o_req0_rvalid = r_rvalid0;
    assign o_req1_rvalid = r_rvalid1;
    assign o_req0_rdata  = r_rdata0;
    assign o_req1_rdata  = r_rdata1;

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int DW  = 14;
    localparam int AW  = 12;
    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // main instance signals
    logic          q_valid [2];
    logic          q_we    [2];
    logic [AW-1:0] q_addr  [2];
    logic [DW-1:0] q_wdata [2];
    logic          o_ready [2];
    logic          o_rvalid[2];
    logic [DW-1:0] o_rdata [2];
    logic          ram_rd, ram_wr, busy, last_grant;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RAM_LAT(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .i_req0_valid(q_valid[0]), .i_req0_we(q_we[0]), .i_req0_addr(q_addr[0]), .i_req0_wdata(q_wdata[0]),
        .o_req0_ready(o_ready[0]), .o_req0_rvalid(o_rvalid[0]), .o_req0_rdata(o_rdata[0]),
        .i_req1_valid(q_valid[1]), .i_req1_we(q_we[1]), .i_req1_addr(q_addr[1]), .i_req1_wdata(q_wdata[1]),
        .o_req1_ready(o_ready[1]), .o_req1_rvalid(o_rvalid[1]), .o_req1_rdata(o_rdata[1]),
        .o_ram_rd(ram_rd), .o_ram_wr(ram_wr), .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata),
        .i_ram_rdata(ram_rdata), .o_busy(busy), .o_last_grant(last_grant)
    );

    // latency-bound instances (index 0: RAM_LAT=1, index 1: RAM_LAT=15)
    logic          l_valid = 1'b0;
    logic [AW-1:0] l_addr_in = 12'h005;
    logic          l_ready [2], l_rvalid [2], l_r1_ready [2], l_r1_rvalid [2];
    logic [DW-1:0] l_rdata [2], l_r1_rdata [2], l_wdata [2], l_rdat_in [2];
    logic          l_rd [2], l_wr [2], l_busy [2], l_lg [2];
    logic [AW-1:0] l_addr [2];

    ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RAM_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .i_req0_valid(l_valid), .i_req0_we(1'b0), .i_req0_addr(l_addr_in), .i_req0_wdata(14'h0),
        .o_req0_ready(l_ready[0]), .o_req0_rvalid(l_rvalid[0]), .o_req0_rdata(l_rdata[0]),
        .i_req1_valid(1'b0), .i_req1_we(1'b0), .i_req1_addr(12'h0), .i_req1_wdata(14'h0),
        .o_req1_ready(l_r1_ready[0]), .o_req1_rvalid(l_r1_rvalid[0]), .o_req1_rdata(l_r1_rdata[0]),
        .o_ram_rd(l_rd[0]), .o_ram_wr(l_wr[0]), .o_ram_addr(l_addr[0]), .o_ram_wdata(l_wdata[0]),
        .i_ram_rdata(l_rdat_in[0]), .o_busy(l_busy[0]), .o_last_grant(l_lg[0])
    );

    ram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RAM_LAT(15)) u_lat15 (
        .clk(clk), .reset(reset),
        .i_req0_valid(l_valid), .i_req0_we(1'b0), .i_req0_addr(l_addr_in), .i_req0_wdata(14'h0),
        .o_req0_ready(l_ready[1]), .o_req0_rvalid(l_rvalid[1]), .o_req0_rdata(l_rdata[1]),
        .i_req1_valid(1'b0), .i_req1_we(1'b0), .i_req1_addr(12'h0), .i_req1_wdata(14'h0),
        .o_req1_ready(l_r1_ready[1]), .o_req1_rvalid(l_r1_rvalid[1]), .o_req1_rdata(l_r1_rdata[1]),
        .o_ram_rd(l_rd[1]), .o_ram_wr(l_wr[1]), .o_ram_addr(l_addr[1]), .o_ram_wdata(l_wdata[1]),
        .i_ram_rdata(l_rdat_in[1]), .o_busy(l_busy[1]), .o_last_grant(l_lg[1])
    );

    // cycle index: during cycle c (between posedges) tcyc == c
    int tcyc = 0;
    always @(posedge clk) tcyc <= tcyc + 1;

    // RAM environment: data is correct only in the exact latency cycle
    logic [DW-1:0] ram_mem [4096];
    logic [DW-1:0] ref_mem [4096];
    logic [AW-1:0] rd_addr_q = '0;
    int            rd_due = -100;
    always @(posedge clk) begin
        if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
        if (ram_rd) begin
            rd_addr_q <= ram_addr;
            rd_due    <= tcyc + LAT;
        end
    end
    assign ram_rdata = (tcyc == rd_due) ? ram_mem[rd_addr_q] : (ram_mem[rd_addr_q] ^ 14'h2AAA);

    int l_due [2] = '{-100, -100};
    always @(posedge clk) begin
        if (l_rd[0]) l_due[0] <= tcyc + 1;
        if (l_rd[1]) l_due[1] <= tcyc + 15;
    end
    assign l_rdat_in[0] = (tcyc == l_due[0]) ? 14'h1ABC : 14'h0155;
    assign l_rdat_in[1] = (tcyc == l_due[1]) ? 14'h1ABC : 14'h0155;

    // observation monitors
    int            last_rv [2] = '{-1, -1};
    int            rv_cnt  [2] = '{0, 0};
    int            l_acc   [2] = '{-1, -1};
    int            l_rv    [2] = '{-1, -1};
    logic [DW-1:0] l_rvd   [2];
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (o_rvalid[k] === 1'b1) begin
                last_rv[k] = tcyc;
                rv_cnt[k]++;
            end
            if (l_valid && (l_ready[k] === 1'b1)) l_acc[k] = tcyc;
            if (l_rvalid[k] === 1'b1) begin
                l_rv[k]  = tcyc;
                l_rvd[k] = l_rdata[k];
            end
        end
    end

    // reference model: cycle arithmetic over transactions
    int            n_pass  = 0;
    int            n_total = 0;
    int            free_at = 0;
    bit            m_last  = 1'b1;
    bit            rv_pend = 1'b0;
    int            rv_cyc  = 0;
    int            rv_port = 0;
    logic [DW-1:0] rv_data = '0;
    int            iss_cyc = -1;
    bit            iss_we  = 1'b0;
    logic [AW-1:0] e_addr  = '0;
    logic [DW-1:0] e_wdata = '0;
    logic [DW-1:0] e_rdata [2] = '{14'h0, 14'h0};
    int            acc_cyc [2] = '{-1, -1};
    int            acc_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s @cycle %0d: observed 0x%0h expected 0x%0h", tag, tcyc, obs, exp);
    endtask

    task automatic set_req(input int p, input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        q_valid[p] = v;
        q_we[p]    = we;
        q_addr[p]  = a;
        q_wdata[p] = d;
    endtask

    task automatic step();
        bit e_rdy [2];
        int win;
        bit idle;
        @(negedge clk);
        idle     = (tcyc >= free_at) && !reset;
        e_rdy[0] = 1'b0;
        e_rdy[1] = 1'b0;
        win      = -1;
        if (idle) begin
            if (q_valid[0] && q_valid[1]) win = m_last ? 0 : 1;
            else if (q_valid[0])          win = 0;
            else if (q_valid[1])          win = 1;
        end
        if (win >= 0) e_rdy[win] = 1'b1;
        if (rv_pend && rv_cyc == tcyc) e_rdata[rv_port] = rv_data;
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("ready%0d", p),  o_ready[p],  e_rdy[p]);
            chk($sformatf("rvalid%0d", p), o_rvalid[p], rv_pend && rv_cyc == tcyc && rv_port == p);
            chk($sformatf("rdata%0d", p),  o_rdata[p],  e_rdata[p]);
        end
        chk("ram_rd",     ram_rd,     (tcyc == iss_cyc) && !iss_we);
        chk("ram_wr",     ram_wr,     (tcyc == iss_cyc) && iss_we);
        chk("ram_addr",   ram_addr,   e_addr);
        chk("ram_wdata",  ram_wdata,  e_wdata);
        chk("busy",       busy,       tcyc < free_at);
        chk("last_grant", last_grant, m_last);
        if (rv_pend && rv_cyc == tcyc) rv_pend = 1'b0;
        if (reset) begin
            free_at    = tcyc + 1;
            m_last     = 1'b1;
            rv_pend    = 1'b0;
            iss_cyc    = -1;
            e_addr     = '0;
            e_wdata    = '0;
            e_rdata[0] = '0;
            e_rdata[1] = '0;
        end else if (win >= 0) begin
            m_last       = win[0];
            acc_cyc[win] = tcyc;
            acc_q.push_back(win);
            e_addr       = q_addr[win];
            e_wdata      = q_wdata[win];
            iss_cyc      = tcyc + 1;
            iss_we       = q_we[win];
            if (q_we[win]) begin
                free_at = tcyc + 2;
                ref_mem[q_addr[win]] = q_wdata[win];
            end else begin
                free_at = tcyc + LAT + 2;
                rv_pend = 1'b1;
                rv_cyc  = tcyc + LAT + 2;
                rv_port = win;
                rv_data = ref_mem[q_addr[win]];
            end
        end
        @(posedge clk);
        #1;
        if (win >= 0 && !reset) q_valid[win] = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int before0, before1;
        int addr_ctr;
        for (int i = 0; i < 4096; i++) begin
            logic [DW-1:0] v;
            v = DW'($urandom);
            ram_mem[i] = v;
            ref_mem[i] = v;
        end
        ram_mem[5] = 14'h1ABC;
        ref_mem[5] = 14'h1ABC;
        for (int p = 0; p < 2; p++) set_req(p, 1'b0, 1'b0, '0, '0);

        reset = 1'b1;
        @(posedge clk);
        #1;
        run(2);
        reset = 1'b0;

        // latency bounds on the RAM_LAT=1 and RAM_LAT=15 instances
        l_valid = 1'b1;
        t0 = tcyc;
        step();
        l_valid = 1'b0;
        run(20);
        chk("lat1_accept",  l_acc[0], t0);
        chk("lat15_accept", l_acc[1], t0);
        chk("lat1_rvalid_cycle",  l_rv[0], t0 + 3);
        chk("lat15_rvalid_cycle", l_rv[1], t0 + 17);
        chk("lat1_rdata",  l_rvd[0], 14'h1ABC);
        chk("lat15_rdata", l_rvd[1], 14'h1ABC);

        // single read on req0
        before1 = rv_cnt[1];
        set_req(0, 1'b1, 1'b0, 12'h005, 14'h0);
        t0 = tcyc;
        run(6);
        chk("rd_ready0_t0",   acc_cyc[0], t0);
        chk("rd_rvalid0_t4",  last_rv[0], t0 + 4);
        chk("rd_rdata0",      o_rdata[0], 14'h1ABC);
        chk("rd_no_rvalid1",  rv_cnt[1], before1);

        // single write on req1
        before0 = rv_cnt[0];
        set_req(1, 1'b1, 1'b1, 12'h0FF, 14'h2345);
        t0 = tcyc;
        run(3);
        chk("wr_ready1_t0",  acc_cyc[1], t0);
        chk("wr_ram_data",   ram_mem[12'h0FF], 14'h2345);
        chk("wr_no_rvalid",  rv_cnt[0] + rv_cnt[1], before0 + before1);

        // tie with continuously held reads: alternate 0,1,0,1
        acc_q.delete();
        before0  = rv_cnt[0];
        before1  = rv_cnt[1];
        addr_ctr = 0;
        set_req(0, 1'b1, 1'b0, 12'h010, 14'h0);
        set_req(1, 1'b1, 1'b0, 12'h011, 14'h0);
        for (int k = 0; k < 60 && acc_q.size() < 4; k++) begin
            step();
            for (int p = 0; p < 2; p++) begin
                if (!q_valid[p]) begin
                    set_req(p, 1'b1, 1'b0, AW'(12'h012 + addr_ctr), 14'h0);
                    addr_ctr++;
                end
            end
        end
        q_valid[0] = 1'b0;
        q_valid[1] = 1'b0;
        run(LAT + 3);
        chk("rr_count", acc_q.size(), 4);
        for (int k = 0; k < acc_q.size() && k < 4; k++)
            chk($sformatf("rr_order%0d", k), acc_q[k], k % 2);
        chk("rr_rvalid0_count", rv_cnt[0] - before0, 2);
        chk("rr_rvalid1_count", rv_cnt[1] - before1, 2);

        // back-to-back: req1 write accepted in the rvalid0 cycle
        set_req(0, 1'b1, 1'b0, 12'h020, 14'h0);
        step();
        set_req(1, 1'b1, 1'b1, 12'h021, 14'h1111);
        run(6);
        chk("b2b_accept_with_rvalid0", acc_cyc[1], last_rv[0]);
        chk("b2b_accept_gap",          acc_cyc[1], acc_cyc[0] + 4);
        chk("b2b_write_landed",        ram_mem[12'h021], 14'h1111);

        // reset during WAIT: no rvalid, then tie goes to req0
        before0 = rv_cnt[0];
        set_req(0, 1'b1, 1'b0, 12'h030, 14'h0);
        run(2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(8);
        chk("rst_no_rvalid", rv_cnt[0], before0);
        acc_q.delete();
        set_req(0, 1'b1, 1'b0, 12'h031, 14'h0);
        set_req(1, 1'b1, 1'b0, 12'h032, 14'h0);
        for (int k = 0; k < 10 && acc_q.size() == 0; k++) step();
        chk("rst_tie_seen", acc_q.size() > 0, 1'b1);
        if (acc_q.size() > 0) chk("rst_tie_winner", acc_q[0], 0);
        q_valid[0] = 1'b0;
        q_valid[1] = 1'b0;
        run(LAT + 3);

        // randomized traffic with occasional resets
        for (int k = 0; k < 600; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!q_valid[p]) begin
                    if ($urandom_range(2) == 0)
                        set_req(p, 1'b1, 1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom));
                end else if ($urandom_range(15) == 0) begin
                    q_valid[p] = 1'b0;
                end else if ($urandom_range(7) == 0) begin
                    q_addr[p]  = AW'($urandom_range(15));
                    q_wdata[p] = DW'($urandom);
                end
            end
            reset = ($urandom_range(99) == 0);
            step();
        end
        reset      = 1'b0;
        q_valid[0] = 1'b0;
        q_valid[1] = 1'b0;
        run(LAT + 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
